// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the registered N-way select stage: FSM encodings and
// lane slicing math for flattened lane buses.
package mux_pipe_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  // LSB of lane 'lane' within a flattened bus of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N-to-1 lane select. An index past the last lane yields zero
// data with err set, which can only happen when N is not a power of two.
module mux_nx1
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err
);

  always_comb begin
    out_data = '0;
    out_err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        out_data = in_data[lane_lsb(i, WIDTH) +: WIDTH];
        out_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N-way operand select with valid/ready handshake and a two-entry
// skid buffer; full throughput, and ready never depends on out_ready.
module mux_pipe_stage
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  logic [1:0]       state_q;
  beat_t            main_q, skid_q, beat_in;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept, consume;

  mux_nx1 #(.WIDTH(WIDTH), .N(N)) u_sel (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (sel_data),
    .out_err  (sel_err)
  );

  assign beat_in   = '{data: sel_data, err: sel_err};
  assign in_ready  = (state_q != TWO) && !rst;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q.data;
  assign out_err   = main_q.err;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // flush outranks any accept/consume in the same cycle; the offered beat is lost
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_q <= ONE;
          main_q  <= beat_in;
        end
        ONE: begin
          if (accept && consume) begin
            main_q <= beat_in;
          end else if (accept) begin
            state_q <= TWO;
            skid_q  <= beat_in;
          end else if (consume) begin
            state_q <= EMPTY;
          end
        end
        TWO: if (consume) begin
          state_q <= ONE;
          main_q  <= skid_q;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: directed table, 3-lane out-of-range sequence, and
// randomized traffic against a queue-based model of a depth-2 FIFO.
module tb_mux_pipe_stage;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [4*W-1:0] in_data;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;

  logic           flush3, in_valid3, in_ready3, out_valid3, out_ready3, out_err3;
  logic [3*W-1:0] in_data3;
  logic [1:0]     sel3;
  logic [W-1:0]   out_data3;

  mux_pipe_stage #(.WIDTH(W), .N(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe_stage #(.WIDTH(W), .N(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush3), .out_data(out_data3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } beat_t;

  typedef struct {
    logic         r, fl, iv;
    logic [1:0]   s;
    logic         ordy;
    logic         e_rdy, e_ov;
    logic [W-1:0] e_d;
  } vec_t;

  beat_t q[$];
  beat_t held;
  int    nvec = 0;
  int    nerr = 0;

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, compare against the FIFO model, advance model and DUT.
  task automatic cycle(input logic r, input logic fl, input logic iv, input logic [1:0] s,
                       input logic [4*W-1:0] lanes, input logic ordy);
    beat_t b;
    bit    acc, con;
    rst = r; flush = fl; in_valid = iv; sel = s; in_data = lanes; out_ready = ordy;
    #1;
    chk1("in_ready", in_ready, !r && q.size() < 2);
    chk1("out_valid", out_valid, q.size() > 0);
    chkw("out_data", out_data, held.d);
    chk1("out_err", out_err, held.e);
    acc = iv && !r && q.size() < 2;
    con = ordy && q.size() > 0;
    b.d = lanes[int'(s)*W +: W];
    b.e = 1'b0;
    if (r || fl) begin
      q.delete();
      held = '0;
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(b);
      if (q.size() > 0) held = q[0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t           tv[20];
  logic [4*W-1:0] lanes_fix;
  logic [4*W-1:0] rl;

  initial begin
    lanes_fix = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    //          r  fl iv sel   ordy rdy ov data
    tv[0]  = '{1, 0, 0, 2'd0, 1,   0,  0, 32'h0};
    tv[1]  = '{0, 0, 1, 2'd2, 1,   1,  0, 32'h0};
    tv[2]  = '{0, 0, 0, 2'd0, 1,   1,  1, 32'hC2};
    tv[3]  = '{0, 0, 0, 2'd0, 1,   1,  0, 32'hC2};
    tv[4]  = '{0, 0, 1, 2'd0, 0,   1,  0, 32'hC2};
    tv[5]  = '{0, 0, 1, 2'd1, 0,   1,  1, 32'hA0};
    tv[6]  = '{0, 0, 1, 2'd3, 0,   0,  1, 32'hA0};
    tv[7]  = '{0, 0, 1, 2'd3, 1,   0,  1, 32'hA0};
    tv[8]  = '{0, 0, 1, 2'd3, 1,   1,  1, 32'hB1};
    tv[9]  = '{0, 0, 0, 2'd0, 1,   1,  1, 32'hD3};
    tv[10] = '{0, 0, 0, 2'd0, 1,   1,  0, 32'hD3};
    tv[11] = '{0, 0, 1, 2'd0, 0,   1,  0, 32'hD3};
    tv[12] = '{0, 0, 1, 2'd1, 0,   1,  1, 32'hA0};
    tv[13] = '{0, 1, 1, 2'd2, 1,   0,  1, 32'hA0};
    tv[14] = '{0, 0, 0, 2'd0, 1,   1,  0, 32'h0};
    tv[15] = '{0, 0, 0, 2'd0, 1,   1,  0, 32'h0};
    tv[16] = '{0, 0, 1, 2'd3, 0,   1,  0, 32'h0};
    tv[17] = '{0, 0, 1, 2'd2, 0,   1,  1, 32'hD3};
    tv[18] = '{1, 0, 1, 2'd0, 0,   0,  1, 32'hD3};
    tv[19] = '{0, 0, 0, 2'd0, 0,   1,  0, 32'h0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; sel = '0; in_data = '0; out_ready = 1'b0;
    flush3 = 1'b0; in_valid3 = 1'b0; sel3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    held = '0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      rst = tv[i].r; flush = tv[i].fl; in_valid = tv[i].iv; sel = tv[i].s;
      in_data = lanes_fix; out_ready = tv[i].ordy;
      #1;
      chk1($sformatf("tv%0d.in_ready", i), in_ready, tv[i].e_rdy);
      chk1($sformatf("tv%0d.out_valid", i), out_valid, tv[i].e_ov);
      chkw($sformatf("tv%0d.out_data", i), out_data, tv[i].e_d);
      chk1($sformatf("tv%0d.out_err", i), out_err, 1'b0);
      cycle(tv[i].r, tv[i].fl, tv[i].iv, tv[i].s, lanes_fix, tv[i].ordy);
    end

    // streaming: ready must stay high for all 16 beats
    for (int i = 0; i < 16; i++) begin
      rl = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b0, 1'b0, 1'b1, 2'(i % 4), rl, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);

    // 3-lane instance: index 3 is out of range
    in_data3 = {32'h33, 32'h22, 32'h11};
    sel3 = 2'd3; in_valid3 = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk1("n3.out_valid", out_valid3, 1'b1);
    chkw("n3.oor_data", out_data3, 32'h0);
    chk1("n3.oor_err", out_err3, 1'b1);
    sel3 = 2'd1;
    @(posedge clk); @(negedge clk); #1;
    chkw("n3.sel1_data", out_data3, 32'h22);
    chk1("n3.sel1_err", out_err3, 1'b0);
    sel3 = 2'd2;
    @(posedge clk); @(negedge clk); #1;
    chkw("n3.sel2_data", out_data3, 32'h33);
    chk1("n3.in_ready", in_ready3, 1'b1);
    in_valid3 = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    chk1("n3.drained", out_valid3, 1'b0);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      rl = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom % 97) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
            2'($urandom_range(0, 3)), rl, ($urandom % 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
